// File: rtl/shared_port_arb_pkg.sv
// Shared types for the round-robin shared-port arbiter: FSM state encoding
// and the index-width helper used by the arbiter and its picker.
package shared_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    // Width of a requester index; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_port_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// (last + 1) mod NUM_REQ, scanning upward with wrap-around.
module rr_pick
    import shared_port_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate gi is the requester gi+1 positions after the last owner.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, last} + (IDX_W+1)'(gi + 1);
        assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                        : sum[IDX_W-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        found = |hit;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter sharing one single-issue downstream port among NUM_REQ
// requesters. Optional WAIT_DONE hold limit enabled by SHARED_PORT_ARB_TIMEOUT_EN.
module shared_port_arbiter
    import shared_port_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    input  logic                        out_ready_i,
    input  logic                        done_i,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        timeout_o
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_e             state_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [IDX_W-1:0]   last_owner_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               valid_reg;
    logic               busy_reg;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  payload [NUM_REQ];

`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic               timeout_reg;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
        assign payload[gi] = req_data_i[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_i),
        .last  (last_owner_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
            hold_cnt_reg   <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        owner_reg <= pick_idx;
                        data_reg  <= payload[pick_idx];
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_ready_i) begin
                        valid_reg <= 1'b0;
                        state_reg <= WAIT_DONE;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
                        hold_cnt_reg <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        last_owner_reg <= owner_reg;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
                    // This cycle would be the MAX_HOLD-th without done_i.
                    else if (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1)) begin
                        last_owner_reg <= owner_reg;
                        busy_reg       <= 1'b0;
                        timeout_reg    <= 1'b1;
                        state_reg      <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
`endif
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Grant is tied to the live handshake so it pulses in the accepting cycle.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
        assign gnt_o[gi] = (state_reg == ISSUE) && out_ready_i && (owner_reg == IDX_W'(gi));
    end

    assign out_valid_o = valid_reg;
    assign out_data_o  = data_reg;
    assign busy_o      = busy_reg;
    assign owner_o     = owner_reg;

`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Self-checking bench for shared_port_arbiter: transaction-level reference
// model compared every cycle, plus directed literal checks.
module tb_shared_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH = 15;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic            done;
    logic            busy;
    logic [1:0]      owner;
    logic            timeout;

    int n_cmp = 0;
    int n_bad = 0;

    shared_port_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .req_data_i  (req_data),
        .gnt_o       (gnt),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .done_i      (done),
        .busy_o      (busy),
        .owner_o     (owner),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 offering payload, 2 owner holds port.
    int            m_phase, m_owner, m_last, m_hold;
    logic [DW-1:0] m_data;
    logic          m_tmo;
    logic [N-1:0]  gnt_log [$];

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = N - 1; m_hold = 0;
        m_data = '0; m_tmo = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (!rst_n) model_reset();
        eg = '0;
        if (m_phase == 1 && out_ready) eg[m_owner] = 1'b1;
        chk("gnt", gnt, eg);
        chk("valid", out_valid, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("timeout", timeout, m_tmo);
        if (m_phase == 1) chk("data", out_data, m_data);
        if (m_phase != 0) chk("owner", owner, m_owner);
        if (gnt != '0) begin
            gnt_log.push_back(gnt);
            $display("txn grant=%b owner=%0d data=%h t=%0t", gnt, owner, out_data, $time);
        end
        if (rst_n) begin
            m_tmo = 1'b0;
            case (m_phase)
                0: begin
                    for (int k = 1; k <= N; k++) begin
                        int i;
                        i = (m_last + k) % N;
                        if (m_phase == 0 && req[i]) begin
                            m_owner = i;
                            m_data  = req_data[i*DW +: DW];
                            m_phase = 1;
                        end
                    end
                end
                1: if (out_ready) begin m_phase = 2; m_hold = 0; end
                default: begin
                    if (done) begin
                        m_last = m_owner; m_phase = 0;
                    end
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
                    else begin
                        m_hold++;
                        if (m_hold == MH) begin
                            m_tmo = 1'b1; m_last = m_owner; m_phase = 0;
                        end
                    end
`endif
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic wait_hold(input int maxc, input string nm);
        int c = 0;
        while (!(busy === 1'b1 && out_valid === 1'b0) && c < maxc) begin
            tick();
            c++;
        end
        chk(nm, c < maxc, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] p0, p1;
        int k;
        rst_n = 1'b0; req = '0; req_data = '0; out_ready = 1'b0; done = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_data", out_data, '0);
        chk("rst_gnt", gnt, '0);
        chk("rst_timeout", timeout, 1'b0);

        // First issue after reset goes to requester 0.
        rst_n = 1'b1; req = 4'b0101; out_ready = 1'b1; req_data = $urandom;
        p0 = req_data[7:0];
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_owner", owner, 2'd0);
        chk("t1_data", out_data, p0);
        chk("t1_gnt", gnt, 4'b0001);
        tick();
        chk("t1_busy", busy, 1'b1);
        chk("t1_valid_drop", out_valid, 1'b0);

        // Strict rotation with all requesters active.
        req = 4'b1111;
        gnt_log.delete();
        pulse_done();
        for (int t = 0; t < 4; t++) begin
            wait_hold(50, "rot_bound");
            if (t < 3) pulse_done();
        end
        chk("rot_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            chk("rot_0", gnt_log[0], 4'b0010);
            chk("rot_1", gnt_log[1], 4'b0100);
            chk("rot_2", gnt_log[2], 4'b1000);
            chk("rot_3", gnt_log[3], 4'b0001);
        end

        // Back-pressure: payload stable, request drop ignored.
        out_ready = 1'b0;
        pulse_done();
        tick();
        chk("bp_owner", owner, 2'd1);
        p1 = req_data[15:8];
        req[1] = 1'b0;
        req_data[15:8] = ~p1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, p1);
            chk("bp_gnt", gnt, '0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_gnt_rise", gnt, 4'b0010);
        tick();

        // Reset while requester 2 owns the port.
        req = 4'b0100;
        pulse_done();
        wait_hold(20, "own2_bound");
        chk("own2", owner, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_owner", owner, 2'd0);
        chk("arst_data", out_data, '0);
        chk("arst_gnt", gnt, '0);
        tick(); tick();
        req = 4'b1111; rst_n = 1'b1;
        tick();
        chk("arst_restart_owner", owner, 2'd0);
        chk("arst_restart_valid", out_valid, 1'b1);
        req = '0;
        tick();

`ifdef SHARED_PORT_ARB_TIMEOUT_EN
        k = 0;
        while (timeout !== 1'b1 && k < 40) begin tick(); k++; end
        chk("tmo_latency", k, MH);
        chk("tmo_busy", busy, 1'b0);
        req = 4'b0001;
        wait_hold(20, "tmo2_bound");
        req = '0;
        repeat (MH - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("tmo2_timeout", timeout, 1'b0);
        chk("tmo2_busy", busy, 1'b0);
        tick();
`else
        k = 0;
        repeat (100) begin
            tick();
            if (busy === 1'b1 && timeout === 1'b0) k++;
        end
        chk("hold_100", k, 100);
        pulse_done();
`endif

        for (int c = 0; c < 3000; c++) begin
            req       = N'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            done      = ($urandom_range(0, 99) < ((c < 1500) ? 25 : 3));
            rst_n     = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1; done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
